// File: rtl/idma_channel_arbiter.sv
// idma_channel_arbiter
//
// Shares one iDMA backend between NumChannels frontends. A round-robin
// arbiter picks the next requesting channel and keeps that grant stable while
// the backend stalls. Each accepted transfer records its channel index in an
// in-order issue FIFO, so every backend completion pulse is routed back to the
// channel that issued it.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   req_i            per-channel burst request
//   valid_i          per-channel request valid
//   ready_o          per-channel accept (one-hot or zero)
//   burst_req_o      request forwarded to the backend
//   valid_o          request valid to the backend
//   ready_i          backend accept
//   trans_complete_i backend completion pulse, one per transfer, in issue order
//   trans_complete_o completion pulse routed to the issuing channel
//   outstanding_o    per-channel count of issued, uncompleted transfers
//   idle_o           high when no transfer is outstanding
module idma_channel_arbiter #(
    parameter int unsigned NumChannels    = 4,
    parameter int unsigned MaxOutstanding = 8,
    parameter type         burst_req_t    = logic,
    localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  burst_req_t [NumChannels-1:0]         req_i,
    input  logic       [NumChannels-1:0]         valid_i,
    output logic       [NumChannels-1:0]         ready_o,
    output burst_req_t                           burst_req_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    input  logic                                 trans_complete_i,
    output logic       [NumChannels-1:0]         trans_complete_o,
    output logic       [NumChannels-1:0][CntW-1:0] outstanding_o,
    output logic                                 idle_o
);

    localparam int unsigned IdxW = $clog2(NumChannels);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    // Control state
    logic [IdxW-1:0] prio_q;
    logic            locked_q;
    logic [IdxW-1:0] gnt_q;
    logic [PtrW-1:0] wptr_q;
    logic [PtrW-1:0] rptr_q;
    logic [CntW-1:0] count_q;
    logic [NumChannels-1:0][CntW-1:0] outstanding_q;

    // Issue FIFO storage (data only, never reset)
    logic [IdxW-1:0] fifo_q [MaxOutstanding];

    // Combinational helpers
    logic            eff_locked;
    logic [IdxW-1:0] eff_prio;
    logic            eff_full;
    logic            any_valid;
    logic [IdxW-1:0] search_idx;
    logic [IdxW-1:0] cand_idx;
    logic [IdxW-1:0] winner;
    logic            handshake;
    logic            pop;
    logic [IdxW-1:0] head;

    logic            locked_d;
    logic [IdxW-1:0] gnt_d;
    logic [NumChannels-1:0][CntW-1:0] outstanding_d;

    assign head = fifo_q[rptr_q];

    // While reset is asserted the request path behaves as in the unlocked,
    // empty state regardless of the (possibly stale) registers.
    always_comb begin
        eff_locked = locked_q & ~rst_i;
        eff_prio   = rst_i ? '0 : prio_q;
        eff_full   = (count_q == CntW'(MaxOutstanding)) & ~rst_i;
        any_valid  = |valid_i;

        // Scan from the highest offset downwards so the closest requester to
        // prio is the last one written and therefore wins.
        search_idx = '0;
        cand_idx   = '0;
        for (int i = NumChannels - 1; i >= 0; i--) begin
            cand_idx = IdxW'((int'(eff_prio) + i) % int'(NumChannels));
            if (valid_i[cand_idx]) begin
                search_idx = cand_idx;
            end
        end

        winner  = eff_locked ? gnt_q : search_idx;
        valid_o = eff_locked ? valid_i[gnt_q] : (any_valid & ~eff_full);

        if (eff_locked || any_valid) begin
            burst_req_o = req_i[winner];
        end else begin
            burst_req_o = '0;
        end

        handshake = valid_o & ready_i & ~rst_i;
        pop       = trans_complete_i & (count_q != '0) & ~rst_i;

        ready_o = '0;
        if (handshake) begin
            ready_o[winner] = 1'b1;
        end

        trans_complete_o = '0;
        if (pop) begin
            trans_complete_o[head] = 1'b1;
        end
    end

    assign idle_o        = rst_i | (count_q == '0);
    assign outstanding_o = rst_i ? '0 : outstanding_q;

    // Lock next-state: a stalled offer freezes the grant until it completes.
    always_comb begin
        locked_d = locked_q;
        gnt_d    = gnt_q;
        if (handshake) begin
            locked_d = 1'b0;
        end else if (valid_o && !ready_i && !locked_q) begin
            locked_d = 1'b1;
            gnt_d    = winner;
        end
    end

    // Per-channel outstanding counters; a push and pop on the same channel cancel.
    always_comb begin
        outstanding_d = outstanding_q;
        for (int c = 0; c < int'(NumChannels); c++) begin
            if ((handshake && winner == IdxW'(c)) && !(pop && head == IdxW'(c))) begin
                outstanding_d[c] = outstanding_q[c] + CntW'(1);
            end else if (!(handshake && winner == IdxW'(c)) && (pop && head == IdxW'(c))) begin
                outstanding_d[c] = outstanding_q[c] - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q        <= '0;
            locked_q      <= 1'b0;
            gnt_q         <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
        end else begin
            locked_q      <= locked_d;
            gnt_q         <= gnt_d;
            outstanding_q <= outstanding_d;

            if (handshake) begin
                prio_q <= IdxW'((int'(winner) + 1) % int'(NumChannels));
                wptr_q <= (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + PtrW'(1);
            end

            if (handshake && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !handshake) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fifo_q[wptr_q] <= winner;
        end
    end

endmodule

// File: tb/tb_idma_channel_arbiter.sv
// Self-checking bench for idma_channel_arbiter: a vector table for the
// round-robin / completion basics, hand-written multi-cycle sequences for
// stall, full FIFO, push+pop, spurious completion and reset, then random
// stimulus compared against a queue-based reference model.
module tb_idma_channel_arbiter;

    localparam int N  = 4;
    localparam int M  = 8;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0][7:0] req;
    logic [N-1:0]      valid;
    logic              ready;
    logic              tc;
    logic [N-1:0]      ready_o;
    logic [7:0]        breq;
    logic              valid_o;
    logic [N-1:0]      tco;
    logic [N-1:0][CW-1:0] outst;
    logic              idle;

    int nchk = 0;
    int nerr = 0;

    idma_channel_arbiter #(
        .NumChannels   (N),
        .MaxOutstanding(M),
        .burst_req_t   (logic [7:0])
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_i           (req),
        .valid_i         (valid),
        .ready_o         (ready_o),
        .burst_req_o     (breq),
        .valid_o         (valid_o),
        .ready_i         (ready),
        .trans_complete_i(tc),
        .trans_complete_o(tco),
        .outstanding_o   (outst),
        .idle_o          (idle)
    );

    always #5 clk = ~clk;

    // Reference model state
    int  prio_m;
    bit  locked_m;
    int  gnt_m;
    int  q_m[$];
    int  cnt_m[N];

    // Model predictions for the current cycle
    bit          e_valid;
    logic [3:0]  e_ready;
    logic [7:0]  e_req;
    logic [3:0]  e_tc;
    logic [15:0] e_out;
    bit          e_idle;
    int          e_win;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic predict();
        int  pr;
        bit  lk;
        bit  full;
        bit  anyv;
        pr   = rst ? 0 : prio_m;
        lk   = rst ? 1'b0 : locked_m;
        full = !rst && (q_m.size() == M);
        anyv = (valid != 0);
        e_win = 0;
        for (int k = 0; k < N; k++) begin
            if (valid[(pr + k) % N]) begin
                e_win = (pr + k) % N;
                break;
            end
        end
        if (lk) e_win = gnt_m;
        e_valid = lk ? valid[gnt_m] : (anyv && !full);
        e_req   = (lk || anyv) ? req[e_win] : 8'h00;
        e_ready = (!rst && ready && e_valid) ? 4'(1 << e_win) : 4'h0;
        e_tc    = (!rst && tc && q_m.size() > 0) ? 4'(1 << q_m[0]) : 4'h0;
        for (int c = 0; c < N; c++) e_out[4*c +: 4] = rst ? 4'h0 : 4'(cnt_m[c]);
        e_idle  = rst || (q_m.size() == 0);
    endtask

    task automatic update();
        int h;
        if (rst) begin
            prio_m = 0; locked_m = 1'b0; gnt_m = 0;
            q_m.delete();
            for (int c = 0; c < N; c++) cnt_m[c] = 0;
        end else begin
            if (tc && q_m.size() > 0) begin
                h = q_m.pop_front();
                cnt_m[h]--;
            end
            if (e_valid && ready) begin
                q_m.push_back(e_win);
                cnt_m[e_win]++;
                prio_m   = (e_win + 1) % N;
                locked_m = 1'b0;
            end else if (e_valid && !ready && !locked_m) begin
                locked_m = 1'b1;
                gnt_m    = e_win;
            end
        end
    endtask

    task automatic check_model();
        chk("valid_o", 32'(valid_o), 32'(e_valid));
        chk("ready_o", 32'(ready_o), 32'(e_ready));
        chk("burst_req_o", 32'(breq), 32'(e_req));
        chk("trans_complete_o", 32'(tco), 32'(e_tc));
        chk("outstanding_o", 32'(outst), 32'(e_out));
        chk("idle_o", 32'(idle), 32'(e_idle));
    endtask

    task automatic settle();
        #1;
        predict();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        update();
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        check_model();
        tick();
    endtask

    typedef struct {
        bit          rst;
        logic [3:0]  valid;
        bit          ready;
        bit          tc;
        bit          e_valid;
        logic [3:0]  e_ready;
        logic [7:0]  e_req;
        logic [3:0]  e_tc;
        logic [15:0] e_out;
        bit          e_idle;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [15:0] sum_out(input logic [N-1:0][CW-1:0] o);
        logic [15:0] s;
        s = 0;
        for (int c = 0; c < N; c++) s += 16'(o[c]);
        return s;
    endfunction

    initial begin
        //           rst valid  rdy tc  v  rdy_o  req    tc_o  out       idle
        tbl[0]  = '{1, 4'hF, 1, 0, 1, 4'h0, 8'hA0, 4'h0, 16'h0000, 1};
        tbl[1]  = '{0, 4'hF, 1, 0, 1, 4'h1, 8'hA0, 4'h0, 16'h0000, 1};
        tbl[2]  = '{0, 4'hF, 1, 0, 1, 4'h2, 8'hA1, 4'h0, 16'h0001, 0};
        tbl[3]  = '{0, 4'hF, 1, 0, 1, 4'h4, 8'hA2, 4'h0, 16'h0011, 0};
        tbl[4]  = '{0, 4'hF, 1, 0, 1, 4'h8, 8'hA3, 4'h0, 16'h0111, 0};
        tbl[5]  = '{0, 4'hF, 1, 0, 1, 4'h1, 8'hA0, 4'h0, 16'h1111, 0};
        tbl[6]  = '{0, 4'h0, 1, 0, 0, 4'h0, 8'h00, 4'h0, 16'h1112, 0};
        tbl[7]  = '{0, 4'h0, 0, 1, 0, 4'h0, 8'h00, 4'h1, 16'h1112, 0};
        tbl[8]  = '{0, 4'h0, 0, 1, 0, 4'h0, 8'h00, 4'h2, 16'h1111, 0};
        tbl[9]  = '{0, 4'h0, 0, 1, 0, 4'h0, 8'h00, 4'h4, 16'h1101, 0};
        tbl[10] = '{0, 4'h0, 0, 1, 0, 4'h0, 8'h00, 4'h8, 16'h1001, 0};
        tbl[11] = '{0, 4'h0, 0, 1, 0, 4'h0, 8'h00, 4'h1, 16'h0001, 0};
        tbl[12] = '{0, 4'h0, 0, 1, 0, 4'h0, 8'h00, 4'h0, 16'h0000, 1};
        tbl[13] = '{0, 4'h0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 16'h0000, 1};

        prio_m = 0; locked_m = 1'b0; gnt_m = 0;
        for (int c = 0; c < N; c++) cnt_m[c] = 0;

        req = 32'hA3A2A1A0;
        rst = 1'b1; valid = '0; ready = 1'b0; tc = 1'b0;

        // Round-robin fairness and completion routing
        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst; valid = tbl[i].valid; ready = tbl[i].ready; tc = tbl[i].tc;
            settle();
            chk($sformatf("tbl%0d valid_o", i), 32'(valid_o), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d ready_o", i), 32'(ready_o), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d burst_req_o", i), 32'(breq), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d trans_complete_o", i), 32'(tco), 32'(tbl[i].e_tc));
            chk($sformatf("tbl%0d outstanding_o", i), 32'(outst), 32'(tbl[i].e_out));
            chk($sformatf("tbl%0d idle_o", i), 32'(idle), 32'(tbl[i].e_idle));
            tick();
        end

        // Grant stability under stall (prio currently 1)
        valid = 4'b0100; ready = 1'b0; tc = 1'b0;
        settle(); check_model();
        chk("stall c1 req", 32'(breq), 32'hA2);
        chk("stall c1 ready", 32'(ready_o), 32'h0);
        tick();
        valid = 4'b0101;
        settle(); check_model();
        chk("stall c2 req", 32'(breq), 32'hA2);
        tick();
        settle(); check_model();
        chk("stall c3 req", 32'(breq), 32'hA2);
        chk("stall c3 ready", 32'(ready_o), 32'h0);
        tick();
        ready = 1'b1;
        settle(); check_model();
        chk("stall c4 ready", 32'(ready_o), 32'h4);
        chk("stall c4 req", 32'(breq), 32'hA2);
        tick();
        valid = 4'b0001;
        settle(); check_model();
        chk("stall c5 ch0 grant", 32'(ready_o), 32'h1);
        tick();
        valid = '0; tc = 1'b1;
        repeat (2) cycle();
        tc = 1'b0;

        // FIFO full and back-pressure
        valid = 4'b0001; ready = 1'b1;
        repeat (M) cycle();
        settle(); check_model();
        chk("full valid_o", 32'(valid_o), 32'h0);
        chk("full ready_o", 32'(ready_o), 32'h0);
        tick();
        tc = 1'b1;
        settle(); check_model();
        chk("full pop valid_o", 32'(valid_o), 32'h0);
        chk("full pop tc_o", 32'(tco), 32'h1);
        tick();
        tc = 1'b0;
        settle(); check_model();
        chk("full relieved ready_o", 32'(ready_o), 32'h1);
        tick();

        // Simultaneous push and pop at count 3
        valid = '0; tc = 1'b1;
        repeat (M - 3) cycle();
        valid = 4'b0010; ready = 1'b1; tc = 1'b1;
        cycle();
        valid = '0; tc = 1'b0;
        settle(); check_model();
        chk("pushpop count", 32'(sum_out(outst)), 32'd3);
        chk("pushpop idle", 32'(idle), 32'h0);
        tick();
        tc = 1'b1;
        repeat (3) cycle();

        // Spurious completion while empty
        settle();
        chk("spurious tc_o", 32'(tco), 32'h0);
        chk("spurious idle", 32'(idle), 32'h1);
        tick();
        tc = 1'b0;
        settle();
        chk("spurious counters", 32'(outst), 32'h0);
        tick();

        // Reset mid-operation: 5 outstanding, locked on ch2
        valid = 4'b0010; ready = 1'b1;
        repeat (5) cycle();
        valid = 4'b0100; ready = 1'b0;
        cycle();
        valid = 4'b0101;
        settle(); check_model();
        chk("locked req ch2", 32'(breq), 32'hA2);
        tick();
        rst = 1'b1;
        settle(); check_model();
        chk("rst ready_o", 32'(ready_o), 32'h0);
        chk("rst idle", 32'(idle), 32'h1);
        tick();
        rst = 1'b0; valid = 4'b1001; ready = 1'b1;
        settle(); check_model();
        chk("post-rst idle", 32'(idle), 32'h1);
        chk("post-rst outstanding", 32'(outst), 32'h0);
        chk("post-rst grant ch0", 32'(ready_o), 32'h1);
        tick();
        valid = '0; ready = 1'b0; tc = 1'b1;
        cycle();
        tc = 1'b1;
        settle(); check_model();
        tick();
        tc = 1'b0;

        // Randomized stimulus against the reference model
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            valid = 4'($urandom);
            req   = $urandom;
            ready = ($urandom_range(0, 3) != 0);
            tc    = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/idma_channel_arbiter.md
# idma_channel_arbiter

Shares one iDMA backend between `NumChannels` frontends, e.g. several 64-bit register frontends. Round-robin arbitration with a stable grant while the backend stalls. Every accepted transfer is recorded in an in-order issue FIFO, so each backend completion pulse is routed back to the channel that issued it. Sits between the frontends' burst request/valid/ready ports and the backend's request and completion ports.

## Interface
- `NumChannels`, 4, number of requesting frontends; must be ≥2.
- `MaxOutstanding`, 8, issue FIFO depth; max transfers accepted but not completed; must be ≥1.
- `burst_req_t`, logic, backend burst request type, passed through unmodified.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  NumChannels × burst_req_t  per-channel burst request.
- `valid_i`  in  NumChannels  per-channel request valid.
- `ready_o`  out  NumChannels  per-channel accept; at most one bit high.
- `burst_req_o`  out  burst_req_t  request to backend.
- `valid_o`  out  1  request valid to backend.
- `ready_i`  in  1  backend accept.
- `trans_complete_i`  in  1  backend completion pulse; one per transfer, in issue order.
- `trans_complete_o`  out  NumChannels  routed completion pulse; at most one bit high.
- `outstanding_o`  out  NumChannels × $clog2(MaxOutstanding+1)  per-channel count of issued, uncompleted transfers.
- `idle_o`  out  1  high when the issue FIFO is empty.

## Operation
- **State**
  - Round-robin pointer `prio` (0..NumChannels-1).
  - Grant lock `locked` plus locked channel index `gnt_q`.
  - Issue FIFO holding channel indices, with read/write pointers and a `count` of width $clog2(MaxOutstanding+1).
  - Per-channel outstanding counters.
- **Arbitration (`locked`=0)**
  - The winner is the first channel `k` with `valid_i[k]`=1, searching `prio`, `prio+1`, … modulo NumChannels.
  - `valid_o` = any `valid_i` AND `count` < MaxOutstanding.
  - `burst_req_o` = `req_i[winner]`. When no channel wins, `burst_req_o` = '0.
- **Lock state (`locked`=1)**
  - The winner is forced to `gnt_q`.
  - `valid_o` = `valid_i[gnt_q]`. Upstream must hold valid, so this is normally 1.
- **Lock entry and exit**
  - Lock entry: `valid_o`=1 and `ready_i`=0 sets `locked`=1 and `gnt_q`=winner.
  - Lock exit: the handshake clears `locked`.
- **Ready**
  - `ready_o[winner]` = `ready_i` AND `valid_o`.
  - All other `ready_o` bits are 0.
- **Handshake** (`valid_o` AND `ready_i`)
  - Push the winner index into the FIFO.
  - Increment `outstanding[winner]`.
  - Set `prio` = (winner+1) mod NumChannels.
- **Completion** (`trans_complete_i`=1 and `count`>0)
  - Pop the FIFO head `h`.
  - `trans_complete_o[h]`=1 in the same cycle (combinational from the head).
  - Decrement `outstanding[h]`.
- **Full FIFO**
  - Full is evaluated on the registered `count`; there is no pop-to-push bypass.
  - When `count`=MaxOutstanding: `valid_o`=0 and all `ready_o`=0 while not locked.
  - The lock cannot be entered while full.
- **Spurious completion**: `trans_complete_i` while the FIFO is empty is ignored. No output pulse, no state change.
- **Simultaneous push and pop**
  - `count` is unchanged; both pointers advance.
  - If push and pop hit the same channel, its outstanding counter is unchanged.
- **Pointer wrap**: FIFO pointers wrap modulo MaxOutstanding; `count` distinguishes full from empty.
- **Reset**
  - Clears `locked`, `gnt_q`, `prio`=0, FIFO pointers, `count`, and all outstanding counters.
  - Reset mid-transfer discards in-flight bookkeeping; later backend completions are treated as spurious.
- `idle_o` = (`count`==0).

## Timing
- Request path is zero-latency combinational: `valid_i` → `valid_o`/`burst_req_o`, and `ready_i` → `ready_o`.
- Completion routing is zero-latency: `trans_complete_i` → `trans_complete_o`.
- **Reset values** (hold while `rst_i`=1)
  - `ready_o`=0, `trans_complete_o`=0, `outstanding_o`=0, `idle_o`=1.
  - `valid_o` and `burst_req_o` reflect the inputs combinationally as in the unlocked, empty state. No handshake takes effect during reset.
- **Register updates** (next cycle after the triggering edge)
  - `outstanding_o` and `idle_o` update one cycle after the handshake or completion.
  - `prio` takes effect for the next arbitration cycle.
- **Throughput**
  - One transfer per cycle when `ready_i` stays high and the FIFO is not full.
  - A full FIFO relieved by a pop in cycle t allows an issue in cycle t+1.

## Test plan
- **Round-robin fairness**
  - Stimulus: reset; all 4 channels hold `valid_i` with distinct `req_i`; `ready_i`=1.
  - Required: grants in order 0,1,2,3,0.
  - Required: `outstanding_o` = 2,1,1,1 after 5 cycles; `idle_o`=0.
- **Grant stability under stall**
  - Stimulus: ch2 only valid; `ready_i`=0 for 3 cycles; ch0 asserts valid in cycle 2; `ready_i`=1 in cycle 4.
  - Required: `burst_req_o`=`req_i[2]` throughout; `ready_o[2]` pulses in cycle 4.
  - Required: ch0 is granted in cycle 5.
- **Completion routing**
  - Stimulus: issue ch1, ch3, ch1; then 3 `trans_complete_i` pulses on consecutive cycles.
  - Required: `trans_complete_o` = 4'b0010, 4'b1000, 4'b0010.
  - Required: all outstanding counters end at 0 and `idle_o`=1.
- **FIFO full and back-pressure**
  - Stimulus: MaxOutstanding=8; issue 8 transfers on ch0 with no completions.
  - Required: 9th request sees `valid_o`=0 and `ready_o`=0.
  - Stimulus: one completion in cycle t.
  - Required: 9th request accepted in cycle t+1.
- **Simultaneous push and pop plus spurious completion**
  - Stimulus: with count=3, handshake and completion in the same cycle.
  - Required: count stays 3.
  - Stimulus: `trans_complete_i` while empty.
  - Required: no `trans_complete_o` pulse, counters unchanged.
- **Reset mid-operation**
  - Stimulus: 5 outstanding, locked on ch2; assert `rst_i` for 1 cycle.
  - Required: `idle_o`=1, all `outstanding_o`=0, lock cleared, next grant searches from ch0.
